death_screen_ctrl: RTL and testbench
====================================

Name: death_screen_ctrl

Overview:
- Game-over sequencer that owns the death-screen text overlay enable (Death_Text) and the game freeze/restart controls.
- Detects player death, holds a dying delay counted in video frames, then shows the death text with a blinking restart line.
- Waits for a fresh press of the restart key, issues a one-cycle game reset, and returns to play.
- Sits between game logic (player_dead), the keyboard keycode path and the text overlay / colour mapper.

Parameters:
DYING_FRAMES, 60, number of frame ticks spent in DYING before the text appears (>=1)
MIN_SHOW_FRAMES, 30, minimum frame ticks in SHOW before a restart is accepted
BLINK_FRAMES, 30, frame ticks per half-period of restart_blink (>=1)
RESTART_KEY, 8'h28, keycode that requests restart (Enter)

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-low reset
frame_sync  in  1  vsync-derived level; each rising edge is one frame tick
player_dead  in  1  level from game logic, high while the player is dead
keycode  in  8  current key; 8'h00 = no key
Death_Text  out  1  enables the death-screen text overlay
restart_blink  out  1  high while the "press to restart" line is visible
game_freeze  out  1  halts game motion updates
game_reset  out  1  one-CLK restart pulse to game state
state_dbg  out  3  current state encoding, for hex display

Behaviour:
- One clock, CLK; RESET is asynchronous and active-low, and all flops clear on RESET low.
- Reset values: state=PLAY, all outputs 0, counters 0, key_armed 0, sync_q=1 (no spurious tick on release).
- Frame tick: tick = frame_sync & ~sync_q, where sync_q is frame_sync registered. Exactly one CLK-wide tick per rising edge.
- Outputs are Moore-decoded from registered state, except restart_blink, which is its own register. Latency is 1 CLK from the deciding edge.
- State encodings: PLAY=0, DYING=1, SHOW=2, RESTART=3, RELEASE=4.
- PLAY: all outputs 0. player_dead=1 -> DYING, frame_cnt=0. A tick in the same cycle is not counted.
- DYING: game_freeze=1, Death_Text=0.
  - Each tick increments frame_cnt.
  - A tick with frame_cnt==DYING_FRAMES-1 -> SHOW, so DYING spans exactly DYING_FRAMES ticks.
  - On that transition: frame_cnt=0, blink_cnt=0, restart_blink=1, key_armed=0.
- SHOW: Death_Text=1, game_freeze=1.
  - frame_cnt increments on ticks and saturates at MIN_SHOW_FRAMES.
  - blink_cnt counts ticks. At BLINK_FRAMES-1 plus a tick: wraps to 0 and restart_blink toggles.
  - key_armed sets once keycode==8'h00 is seen.
  - Restart is accepted when key_armed=1, keycode==RESTART_KEY and frame_cnt>=MIN_SHOW_FRAMES -> RESTART.
- RESTART: game_reset=1 for exactly one CLK; Death_Text=0, restart_blink=0, game_freeze=1; unconditional -> RELEASE.
- RELEASE: game_freeze=1, other outputs 0. When keycode!=RESTART_KEY and player_dead==0 -> PLAY, counters cleared.
- Boundary cases:
  - player_dead dropping in DYING or SHOW is ignored; the sequence completes.
  - A restart key already held on entry to SHOW is not accepted until released to 00 and pressed again.
  - Other keys pressed in SHOW neither arm nor trigger, except that 00 arms.
  - RESET low mid-sequence returns immediately to PLAY with all outputs 0, including an in-progress game_reset pulse.
  - frame_sync stuck high produces no ticks, so the FSM holds in DYING or SHOW.
  - Illegal state encodings (5-7) recover to PLAY on the next CLK.
- Width rules: frame_cnt and blink_cnt are sized by $clog2 of max(DYING_FRAMES, MIN_SHOW_FRAMES+1) and BLINK_FRAMES. No overflow is possible because of saturation and wrap.

Test Plan:
All cases use DYING_FRAMES=3, MIN_SHOW_FRAMES=4, BLINK_FRAMES=2 and RESTART_KEY=8'h28.
1. Reset and tick check: RESET low with frame_sync=1, then release -> all outputs 0, state_dbg=0, no tick counted until frame_sync falls and rises.
2. Dying delay: player_dead=1 for one cycle, then 3 frame ticks -> state_dbg=1 for exactly 3 ticks, game_freeze=1, Death_Text rises 1 CLK after the 3rd tick.
3. Blink cadence: stay in SHOW for 8 ticks -> restart_blink pattern 1,1,0,0,1,1,0,0 per tick.
4. Restart gating:
   - Enter held from before SHOW -> no restart.
   - keycode=00, then 28 after 2 ticks -> still no restart (frame_cnt<4).
   - 28 after the 4th tick -> game_reset high exactly 1 CLK, state_dbg 3 then 4.
5. Release wait: in RELEASE, hold keycode=28 for 10 cycles with player_dead=1 -> stays at 4. Set keycode=00, player_dead=0 -> PLAY next CLK, game_freeze=0.
6. Async reset mid-sequence: assert RESET low between CLK edges during SHOW and during the RESTART cycle -> outputs clear immediately, state_dbg=0 after release.

Source files
------------

// File: rtl/death_screen_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : death_screen_ctrl
// Purpose  : Game-over sequencer. Detects player death, waits a dying delay
//            counted in video frames, shows the death text with a blinking
//            restart line, waits for a fresh restart key press, pulses a
//            one-clock game reset and returns to play.
// Ports    : CLK           - system clock
//            RESET         - asynchronous active-low reset
//            frame_sync    - vsync-derived level, rising edge = frame tick
//            player_dead   - high while the player is dead
//            keycode[7:0]  - current key, 8'h00 = no key
//            Death_Text    - death-screen text overlay enable
//            restart_blink - "press to restart" line visible
//            game_freeze   - halts game motion updates
//            game_reset    - one-clock restart pulse
//            state_dbg[2:0]- current state encoding
// Revision : 1.0 - initial release
// ============================================================================
module death_screen_ctrl #(
  parameter int         DYING_FRAMES    = 60,
  parameter int         MIN_SHOW_FRAMES = 30,
  parameter int         BLINK_FRAMES    = 30,
  parameter logic [7:0] RESTART_KEY     = 8'h28
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       frame_sync,
  input  logic       player_dead,
  input  logic [7:0] keycode,
  output logic       Death_Text,
  output logic       restart_blink,
  output logic       game_freeze,
  output logic       game_reset,
  output logic [2:0] state_dbg
);

  // frame_cnt must reach DYING_FRAMES-1 and saturate at MIN_SHOW_FRAMES
  localparam int c_FMAX = (DYING_FRAMES > MIN_SHOW_FRAMES + 1) ? DYING_FRAMES
                                                                : MIN_SHOW_FRAMES + 1;
  localparam int c_FW   = ($clog2(c_FMAX) < 1) ? 1 : $clog2(c_FMAX);
  localparam int c_BW   = ($clog2(BLINK_FRAMES) < 1) ? 1 : $clog2(BLINK_FRAMES);

  localparam logic [c_FW-1:0] c_DYING_LAST = c_FW'(DYING_FRAMES - 1);
  localparam logic [c_FW-1:0] c_MIN_SHOW   = c_FW'(MIN_SHOW_FRAMES);
  localparam logic [c_FW-1:0] c_FONE       = c_FW'(1);
  localparam logic [c_BW-1:0] c_BLINK_LAST = c_BW'(BLINK_FRAMES - 1);
  localparam logic [c_BW-1:0] c_BONE       = c_BW'(1);

  typedef enum logic [2:0] {
    ST_PLAY    = 3'd0,
    ST_DYING   = 3'd1,
    ST_SHOW    = 3'd2,
    ST_RESTART = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  state_t          r_state;
  logic            r_sync_q;
  logic [c_FW-1:0] r_frame_cnt;
  logic [c_BW-1:0] r_blink_cnt;
  logic            r_blink;
  logic            r_key_armed;

  state_t          w_state_nxt;
  logic [c_FW-1:0] w_frame_nxt;
  logic [c_BW-1:0] w_blink_cnt_nxt;
  logic            w_blink_nxt;
  logic            w_armed_nxt;
  logic            w_tick;

  // sync_q resets high so a frame_sync already high at reset release
  // does not look like a rising edge.
  assign w_tick = frame_sync & ~r_sync_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= ST_PLAY;
      r_sync_q    <= 1'b1;
      r_frame_cnt <= '0;
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
      r_key_armed <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sync_q    <= frame_sync;
      r_frame_cnt <= w_frame_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
      r_blink     <= w_blink_nxt;
      r_key_armed <= w_armed_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_frame_nxt     = r_frame_cnt;
    w_blink_cnt_nxt = r_blink_cnt;
    w_blink_nxt     = r_blink;
    w_armed_nxt     = r_key_armed;
    Death_Text      = 1'b0;
    game_freeze     = 1'b0;
    game_reset      = 1'b0;

    case (r_state)
      ST_PLAY: begin
        if (player_dead) begin
          w_state_nxt = ST_DYING;
          w_frame_nxt = '0;
        end
      end

      ST_DYING: begin
        game_freeze = 1'b1;
        if (w_tick) begin
          if (r_frame_cnt == c_DYING_LAST) begin
            w_state_nxt     = ST_SHOW;
            w_frame_nxt     = '0;
            w_blink_cnt_nxt = '0;
            w_blink_nxt     = 1'b1;
            w_armed_nxt     = 1'b0;
          end else begin
            w_frame_nxt = r_frame_cnt + c_FONE;
          end
        end
      end

      ST_SHOW: begin
        Death_Text  = 1'b1;
        game_freeze = 1'b1;
        if (w_tick) begin
          if (r_frame_cnt < c_MIN_SHOW) begin
            w_frame_nxt = r_frame_cnt + c_FONE;
          end
          if (r_blink_cnt == c_BLINK_LAST) begin
            w_blink_cnt_nxt = '0;
            w_blink_nxt     = ~r_blink;
          end else begin
            w_blink_cnt_nxt = r_blink_cnt + c_BONE;
          end
        end
        // A key held since before SHOW must be released to 00 first.
        if (keycode == 8'h00) begin
          w_armed_nxt = 1'b1;
        end
        if (r_key_armed && (keycode == RESTART_KEY) && (r_frame_cnt >= c_MIN_SHOW)) begin
          w_state_nxt = ST_RESTART;
          w_blink_nxt = 1'b0;
        end
      end

      ST_RESTART: begin
        game_reset  = 1'b1;
        game_freeze = 1'b1;
        w_blink_nxt = 1'b0;
        w_state_nxt = ST_RELEASE;
      end

      ST_RELEASE: begin
        game_freeze = 1'b1;
        if ((keycode != RESTART_KEY) && !player_dead) begin
          w_state_nxt     = ST_PLAY;
          w_frame_nxt     = '0;
          w_blink_cnt_nxt = '0;
          w_blink_nxt     = 1'b0;
          w_armed_nxt     = 1'b0;
        end
      end

      default: begin
        // Unused encodings fall back to PLAY with everything cleared.
        w_state_nxt     = ST_PLAY;
        w_frame_nxt     = '0;
        w_blink_cnt_nxt = '0;
        w_blink_nxt     = 1'b0;
        w_armed_nxt     = 1'b0;
      end
    endcase
  end

  assign restart_blink = r_blink;
  assign state_dbg     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_death_screen_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_death_screen_ctrl
// Purpose  : Directed self-checking bench for death_screen_ctrl with
//            DYING_FRAMES=3, MIN_SHOW_FRAMES=4, BLINK_FRAMES=2, key 8'h28.
//            Inputs change and outputs are sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_death_screen_ctrl;

  logic       CLK;
  logic       RESET;
  logic       frame_sync;
  logic       player_dead;
  logic [7:0] keycode;
  logic       Death_Text;
  logic       restart_blink;
  logic       game_freeze;
  logic       game_reset;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  death_screen_ctrl #(
    .DYING_FRAMES    (3),
    .MIN_SHOW_FRAMES (4),
    .BLINK_FRAMES    (2),
    .RESTART_KEY     (8'h28)
  ) u_dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .frame_sync    (frame_sync),
    .player_dead   (player_dead),
    .keycode       (keycode),
    .Death_Text    (Death_Text),
    .restart_blink (restart_blink),
    .game_freeze   (game_freeze),
    .game_reset    (game_reset),
    .state_dbg     (state_dbg)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  // One low cycle, then one high cycle; returns on the falling edge just
  // after the clock edge that consumed the tick.
  task automatic tick();
    cyc(1);
    frame_sync = 1'b1;
    cyc(1);
    frame_sync = 1'b0;
  endtask

  task automatic die_to_show();
    player_dead = 1'b1;
    cyc(1);
    player_dead = 1'b0;
    tick();
    tick();
    tick();
  endtask

  logic [7:0] blink_exp [8] = '{8'd1, 8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd0, 8'd0};

  initial begin
    RESET       = 1'b0;
    frame_sync  = 1'b1;
    player_dead = 1'b0;
    keycode     = 8'h00;

    // ---- 1. reset and tick qualification ----
    cyc(3);
    RESET = 1'b1;
    cyc(1);
    chk("rst_state",  state_dbg,     8'd0);
    chk("rst_text",   Death_Text,    8'd0);
    chk("rst_blink",  restart_blink, 8'd0);
    chk("rst_freeze", game_freeze,   8'd0);
    chk("rst_greset", game_reset,    8'd0);

    // ---- 2. dying delay ----
    player_dead = 1'b1;
    cyc(1);
    player_dead = 1'b0;
    keycode     = 8'h28;             // Enter held from before SHOW
    chk("dying_state",  state_dbg,   8'd1);
    chk("dying_freeze", game_freeze, 8'd1);
    chk("dying_text",   Death_Text,  8'd0);
    cyc(3);                          // frame_sync stuck high: no ticks
    chk("stuck_high_hold", state_dbg, 8'd1);
    frame_sync = 1'b0;
    tick();
    chk("dying_t1", state_dbg, 8'd1);
    tick();
    chk("dying_t2", state_dbg, 8'd1);
    cyc(1);
    frame_sync = 1'b1;
    chk("text_before_t3", Death_Text, 8'd0);
    cyc(1);
    frame_sync = 1'b0;
    chk("show_state",  state_dbg,   8'd2);
    chk("show_text",   Death_Text,  8'd1);
    chk("show_freeze", game_freeze, 8'd1);

    // ---- 3. blink cadence, Enter still held so no restart ----
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("blink_f%0d", i), restart_blink, blink_exp[i]);
      chk($sformatf("held_no_rst_f%0d", i), state_dbg, 8'd2);
      tick();
    end

    // ---- 4a. other keys neither arm nor trigger ----
    keycode = 8'h29;
    cyc(2);
    chk("other_key", state_dbg, 8'd2);
    keycode = 8'h28;
    cyc(2);
    chk("unarmed_enter", state_dbg, 8'd2);
    keycode = 8'h00;
    cyc(1);
    keycode = 8'h28;
    cyc(1);
    chk("restart_state",  state_dbg,     8'd3);
    chk("restart_pulse",  game_reset,    8'd1);
    chk("restart_text",   Death_Text,    8'd0);
    chk("restart_blink",  restart_blink, 8'd0);
    chk("restart_freeze", game_freeze,   8'd1);
    cyc(1);
    chk("release_state", state_dbg,   8'd4);
    chk("release_pulse", game_reset,  8'd0);
    chk("release_text",  Death_Text,  8'd0);

    // ---- 5. release wait ----
    player_dead = 1'b1;
    cyc(10);
    chk("release_hold_key", state_dbg, 8'd4);
    keycode = 8'h00;
    cyc(2);
    chk("release_hold_dead", state_dbg, 8'd4);
    player_dead = 1'b0;
    cyc(1);
    chk("play_state",  state_dbg,   8'd0);
    chk("play_freeze", game_freeze, 8'd0);

    // ---- 4b. minimum show time gating ----
    die_to_show();
    chk("gate_show", state_dbg, 8'd2);
    tick();
    tick();
    keycode = 8'h28;
    cyc(2);
    chk("gate_fc2", state_dbg, 8'd2);
    tick();
    chk("gate_fc3", state_dbg, 8'd2);
    tick();
    chk("gate_fc4_edge", state_dbg, 8'd2);
    cyc(1);
    chk("gate_restart",       state_dbg,  8'd3);
    chk("gate_pulse_hi",      game_reset, 8'd1);
    cyc(1);
    chk("gate_release",       state_dbg,  8'd4);
    chk("gate_pulse_lo",      game_reset, 8'd0);
    keycode = 8'h00;
    cyc(1);
    chk("gate_back_play", state_dbg, 8'd0);

    // ---- 6a. async reset during SHOW ----
    die_to_show();
    chk("ar_show_text", Death_Text, 8'd1);
    #2 RESET = 1'b0;
    #1;
    chk("ar_show_text_clr",   Death_Text,    8'd0);
    chk("ar_show_freeze_clr", game_freeze,   8'd0);
    chk("ar_show_blink_clr",  restart_blink, 8'd0);
    chk("ar_show_state_clr",  state_dbg,     8'd0);
    @(negedge CLK);
    RESET = 1'b1;
    cyc(1);
    chk("ar_show_after", state_dbg, 8'd0);

    // ---- 6b. async reset during the RESTART cycle ----
    die_to_show();
    for (int i = 0; i < 4; i++) tick();
    keycode = 8'h28;
    cyc(1);
    chk("ar_rst_pulse", game_reset, 8'd1);
    #2 RESET = 1'b0;
    #1;
    chk("ar_rst_pulse_clr",  game_reset,  8'd0);
    chk("ar_rst_freeze_clr", game_freeze, 8'd0);
    chk("ar_rst_state_clr",  state_dbg,   8'd0);
    @(negedge CLK);
    RESET   = 1'b1;
    keycode = 8'h00;
    cyc(1);
    chk("ar_rst_after", state_dbg, 8'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
